pipe_stage_buffer: RTL and testbench
====================================

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL have parameter CTRL_W, default 24: width of control field; control bits are zeroed whenever the stage holds a bubble.
REQ-002 SHALL have parameter DATA_W, default 57: width of datapath field; never force-cleared except by reset.
REQ-003 SHALL have parameter SKID, default 1: 1 gives 2-entry skid mode with registered o_ready; 0 gives 1-entry mode with combinational o_ready.
REQ-004 SHALL have port i_clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port i_reset  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port i_flush  in  1  synchronous flush; discards all held and incoming entries.
REQ-007 SHALL have port i_valid  in  1  upstream entry present.
REQ-008 SHALL have port i_ctrl  in  CTRL_W  upstream control field.
REQ-009 SHALL have port i_data  in  DATA_W  upstream datapath field.
REQ-010 SHALL have port o_ready  out  1  stage can accept an entry this cycle.
REQ-011 SHALL have port o_valid  out  1  output entry present.
REQ-012 SHALL have port o_ctrl  out  CTRL_W  output control field; all-zero when o_valid=0.
REQ-013 SHALL have port o_data  out  DATA_W  output datapath field.
REQ-014 SHALL have port i_ready  in  1  downstream accepts output; i_ready=0 is a stall.
REQ-015 SHALL have port o_count  out  2  entries held (0..2).

Function
REQ-016 SHALL define accept = i_valid & o_ready and retire = o_valid & i_ready, both evaluated in the same cycle.
REQ-017 SHALL implement states EMPTY, ONE, TWO; TWO is reachable only when SKID=1.
REQ-018 In EMPTY: accept -> ONE, output register loads input; otherwise stay in EMPTY.
REQ-019 In ONE: accept&retire -> ONE, output loads input; accept&!retire -> TWO, skid register loads input (SKID=1 only); !accept&retire -> EMPTY; neither -> hold.
REQ-020 In TWO: retire -> ONE, output loads skid register; otherwise hold; no accept is possible.
REQ-021 SKID=1: o_ready SHALL be a register output, equal to (state != TWO); there is no combinational path from i_ready to o_ready.
REQ-022 SKID=0: o_ready SHALL be (!o_valid | i_ready); accept&!retire in ONE is impossible.
REQ-023 Latency SHALL be 1 cycle from accept to o_valid when the stage is empty; entries SHALL leave in strict FIFO order, with no loss or duplication.
REQ-024 o_ctrl SHALL be registered all-zero on every transition into EMPTY; o_data SHALL hold its last value.
REQ-025 i_flush SHALL have priority over all handshake activity: next state EMPTY, o_valid=0, o_ctrl=0, skid entry invalidated, same-cycle accept discarded, o_ready=1 in the next cycle.
REQ-026 o_count SHALL equal 0, 1, 2 for EMPTY, ONE, TWO respectively.
REQ-027 A stall (i_ready=0) with o_valid=1 SHALL hold o_valid, o_ctrl and o_data stable.

Reset
REQ-028 i_reset SHALL override i_flush and all handshakes: state EMPTY, o_valid=0, o_ctrl=0, o_data=0, skid register cleared, o_count=0.
REQ-029 o_ready SHALL be 1 in the first cycle after reset deasserts, in both modes.
REQ-030 Reset asserted mid-operation SHALL discard held entries without any partial output.

Structure
REQ-031 The shared package SHALL hold the state enum (EMPTY/ONE/TWO) and the default CTRL_W/DATA_W constants for the decode/execute stage instance.
REQ-032 A sub-module pipe_payload_reg SHALL be used: an enable-load register with a ctrl-clear input, instantiated once for the output entry and once for the skid entry (skid instance omitted when SKID=0).

Verification
REQ-033 Scenario: reset, then i_valid=1 with ctrl=0x00000A, data=0x1234, i_ready=1 -> next cycle o_valid=1, o_ctrl=0x00000A, o_data=0x1234, o_count=1.
REQ-034 Scenario: SKID=1, hold i_ready=0 and send entries A, B -> o_count=2, o_ready=0, o_data=A held; then raise i_ready -> A then B delivered on consecutive cycles, o_ready returns to 1.
REQ-035 Scenario: stage in TWO, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_count=0, o_ready=1; the flushed entries never appear.
REQ-036 Scenario: back-to-back stream of 100 entries with random i_ready -> output sequence equals input sequence, and o_ready never depends combinationally on i_ready (SKID=1).
REQ-037 Scenario: SKID=0, ONE state, i_ready=0 -> o_ready=0; i_ready=1 with i_valid=1 -> entry replaced in the same cycle and o_count stays 1.
REQ-038 Scenario: assert i_reset and i_flush together while in TWO -> all outputs zero, including o_data=0.

Source files
------------

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types and default widths for the decode/execute pipeline stage buffer.
package pipe_stage_buffer_pkg;

  // Occupancy of the stage; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // Field widths used by the decode/execute stage instance.
  localparam int DEC_EXE_CTRL_W = 24;
  localparam int DEC_EXE_DATA_W = 57;

endpackage

// File: rtl/pipe_payload_reg.sv
// One pipeline entry: load-enabled control/data register whose control field
// can be cleared independently so a bubble never carries stale control bits.
module pipe_payload_reg #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 57
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // Control field: reset and clear zero it, otherwise load captures new control.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
    end
  end

  // Data field: only reset zeroes it; a clear leaves the last value in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_data <= '0;
    end else if (load && !clear) begin
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline stage buffer with optional 2-entry skid so that o_ready
// can be registered and decoupled from the downstream i_ready.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int          CTRL_W = DEC_EXE_CTRL_W,
  parameter int          DATA_W = DEC_EXE_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [1:0]        o_count
);

  buf_state_t        state;
  buf_state_t        next_state;
  logic              ready;
  logic              accept;
  logic              retire;
  logic              out_load;
  logic              out_from_skid;
  logic              out_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] out_ctrl_d;
  logic [DATA_W-1:0] out_data_d;

  assign o_valid = (state != EMPTY);
  assign o_count = state;
  assign o_ready = ready;
  assign accept  = i_valid & ready;
  assign retire  = o_valid & i_ready;

  // State register; reset dominates flush and handshakes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next state and register load/clear controls; flush wins over any handshake.
  always_comb begin
    next_state    = state;
    out_load      = 1'b0;
    out_from_skid = 1'b0;
    out_clear     = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (i_flush) begin
      next_state = EMPTY;
      out_clear  = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            next_state = ONE;
            out_load   = 1'b1;
          end
        end
        ONE: begin
          if (accept && retire) begin
            out_load = 1'b1;
          end else if (accept && (SKID != 0)) begin
            next_state = TWO;
            skid_load  = 1'b1;
          end else if (retire) begin
            next_state = EMPTY;
            out_clear  = 1'b1;
          end
        end
        TWO: begin
          if (retire) begin
            next_state    = ONE;
            out_load      = 1'b1;
            out_from_skid = 1'b1;
            skid_clear    = 1'b1;
          end
        end
        default: begin
          next_state = EMPTY;
          out_clear  = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Output entry source: the skid entry drains first, else the incoming entry.
  always_comb begin
    out_ctrl_d = i_ctrl;
    out_data_d = i_data;
    if (out_from_skid) begin
      out_ctrl_d = skid_ctrl;
      out_data_d = skid_data;
    end
  end

  pipe_payload_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk    (i_clk),
    .reset  (i_reset),
    .load   (out_load),
    .clear  (out_clear),
    .d_ctrl (out_ctrl_d),
    .d_data (out_data_d),
    .q_ctrl (o_ctrl),
    .q_data (o_data)
  );

  if (SKID != 0) begin : g_skid
    logic ready_p1;

    // Registered ready: low only while both entries are occupied.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        ready_p1 <= 1'b1;
      end else begin
        ready_p1 <= (next_state != TWO);
      end
    end

    assign ready = ready_p1;

    pipe_payload_reg #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid_reg (
      .clk    (i_clk),
      .reset  (i_reset),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_ctrl (i_ctrl),
      .d_data (i_data),
      .q_ctrl (skid_ctrl),
      .q_data (skid_data)
    );
  end else begin : g_no_skid
    assign ready     = ~o_valid | i_ready;
    assign skid_ctrl = '0;
    assign skid_data = '0;
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: a skid instance and a single-entry instance
// share stimulus and are each compared against a FIFO-queue reference model.
module tb_pipe_stage_buffer;

  localparam int CW = 24;
  localparam int DW = 57;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          flush_in;
  logic          valid_in;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] data_in;
  logic          rdy_in;

  logic          rdy  [2];
  logic          vld  [2];
  logic [CW-1:0] octl [2];
  logic [DW-1:0] odat [2];
  logic [1:0]    cnt  [2];

  ent_t          q0[$];
  ent_t          q1[$];
  logic [DW-1:0] last_d [2];
  bit            mdl_ok = 1'b0;
  int            n_chk  = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut_skid (
    .i_clk(clk), .i_reset(rst_in), .i_flush(flush_in), .i_valid(valid_in),
    .i_ctrl(ctrl_in), .i_data(data_in), .o_ready(rdy[1]), .o_valid(vld[1]),
    .o_ctrl(octl[1]), .o_data(odat[1]), .i_ready(rdy_in), .o_count(cnt[1])
  );

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut_flat (
    .i_clk(clk), .i_reset(rst_in), .i_flush(flush_in), .i_valid(valid_in),
    .i_ctrl(ctrl_in), .i_data(data_in), .o_ready(rdy[0]), .o_valid(vld[0]),
    .o_ctrl(octl[0]), .o_data(odat[0]), .i_ready(rdy_in), .o_count(cnt[0])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int qsize(input int k);
    return (k != 0) ? q1.size() : q0.size();
  endfunction

  task automatic check_dut(input int k);
    int   sz;
    ent_t f;
    logic er;
    sz = qsize(k);
    f  = '0;
    if (sz > 0) f = (k != 0) ? q1[0] : q0[0];
    er = (k != 0) ? (sz < 2) : (sz == 0 || rdy_in);
    chk($sformatf("valid%0d", k), 64'(vld[k]), 64'(sz > 0));
    chk($sformatf("count%0d", k), 64'(cnt[k]), 64'(sz));
    chk($sformatf("ctrl%0d", k), 64'(octl[k]), 64'(f.c));
    chk($sformatf("data%0d", k), 64'(odat[k]), 64'(last_d[k]));
    chk($sformatf("ready%0d", k), 64'(rdy[k]), 64'(er));
  endtask

  // One clock: drive at negedge, check current outputs, advance model at posedge.
  task automatic tick(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic r, input logic f, input logic rs);
    logic acc0, acc1, ret0, ret1;
    ent_t e;
    valid_in = v; ctrl_in = c; data_in = d; rdy_in = r; flush_in = f; rst_in = rs;
    #1;
    if (mdl_ok) begin
      check_dut(0);
      check_dut(1);
      rdy_in = ~r;
      #1;
      chk("ready1_vs_iready", 64'(rdy[1]), 64'(q1.size() < 2));
      rdy_in = r;
      #1;
    end
    acc1 = v & (q1.size() < 2);
    acc0 = v & (q0.size() == 0 || r);
    ret1 = (q1.size() > 0) & r;
    ret0 = (q0.size() > 0) & r;
    e.c = c; e.d = d;
    @(posedge clk);
    if (rs) begin
      q0.delete(); q1.delete();
      last_d[0] = '0; last_d[1] = '0;
      mdl_ok = 1'b1;
    end else if (f) begin
      q0.delete(); q1.delete();
    end else begin
      if (ret0) void'(q0.pop_front());
      if (ret1) void'(q1.pop_front());
      if (acc0) q0.push_back(e);
      if (acc1) q1.push_back(e);
    end
    if (q0.size() > 0) last_d[0] = q0[0].d;
    if (q1.size() > 0) last_d[1] = q1[0].d;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[DW-1:0];
  endfunction

  initial begin
    rst_in = 1'b1; flush_in = 1'b0; valid_in = 1'b0; rdy_in = 1'b0;
    ctrl_in = '0; data_in = '0;
    last_d[0] = '0; last_d[1] = '0;
    @(negedge clk);
    tick(0, '0, '0, 0, 0, 1);
    tick(0, '0, '0, 0, 0, 1);

    // Single entry into an empty stage
    tick(1, 24'h00000A, 57'h1234, 1, 0, 0);
    chk("s1_valid", 64'(vld[1]), 64'd1);
    chk("s1_ctrl", 64'(octl[1]), 64'h00000A);
    chk("s1_data", 64'(odat[1]), 64'h1234);
    chk("s1_count", 64'(cnt[1]), 64'd1);
    tick(0, '0, '0, 1, 0, 0);

    // Stall with two entries, then drain in order
    tick(1, 24'h0000A1, 57'hAAAA, 0, 0, 0);
    tick(1, 24'h0000B2, 57'hBBBB, 0, 0, 0);
    chk("s2_count", 64'(cnt[1]), 64'd2);
    chk("s2_ready", 64'(rdy[1]), 64'd0);
    chk("s2_headA", 64'(odat[1]), 64'hAAAA);
    tick(0, '0, '0, 1, 0, 0);
    chk("s2_B_next", 64'(odat[1]), 64'hBBBB);
    tick(0, '0, '0, 1, 0, 0);
    chk("s2_ready_back", 64'(rdy[1]), 64'd1);
    tick(0, '0, '0, 1, 0, 0);

    // Flush from the full state with a same-cycle incoming entry
    tick(1, 24'h000C01, 57'hC01, 0, 0, 0);
    tick(1, 24'h000C02, 57'hC02, 0, 0, 0);
    tick(1, 24'h000C03, 57'hC03, 0, 1, 0);
    chk("s3_valid", 64'(vld[1]), 64'd0);
    chk("s3_ctrl", 64'(octl[1]), 64'd0);
    chk("s3_count", 64'(cnt[1]), 64'd0);
    chk("s3_ready", 64'(rdy[1]), 64'd1);
    tick(0, '0, '0, 1, 0, 0);

    // Single-entry mode: stall blocks ready, ready replaces in place
    tick(1, 24'h000D01, 57'hD01, 1, 0, 0);
    tick(1, 24'h000D02, 57'hD02, 0, 0, 0);
    tick(1, 24'h000D03, 57'hD03, 1, 0, 0);
    chk("s4_count0", 64'(cnt[0]), 64'd1);
    chk("s4_data0", 64'(odat[0]), 64'hD03);
    tick(0, '0, '0, 1, 0, 0);

    // Reset together with flush while full clears everything, data included
    tick(1, 24'h000E01, 57'hE01, 0, 0, 0);
    tick(1, 24'h000E02, 57'hE02, 0, 0, 0);
    tick(1, 24'h000E03, 57'hE03, 0, 1, 1);
    chk("s5_data1", 64'(odat[1]), 64'd0);
    chk("s5_ctrl1", 64'(octl[1]), 64'd0);
    chk("s5_count1", 64'(cnt[1]), 64'd0);
    tick(0, '0, '0, 1, 0, 0);

    // Random stream without flush
    for (int i = 0; i < 300; i++)
      tick(1'($urandom_range(0, 3) != 0), CW'($urandom()), rnd_data(),
           1'($urandom_range(0, 2) != 0), 0, 0);

    // Random stream with occasional flush and reset
    for (int i = 0; i < 200; i++)
      tick(1'($urandom_range(0, 1)), CW'($urandom()), rnd_data(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 59) == 0));

    for (int i = 0; i < 4; i++) tick(0, '0, '0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
